// File: rtl/noc_pkg.sv
// Shared definitions for the opsum collector slice: lane count and collector FSM states.
package noc_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } collector_state_t;

endpackage

// File: rtl/gon_word_buffer.sv
// Single-entry output register towards the GON FIFO.
// A load always wins; a drain without a load empties the entry.
module gon_word_buffer #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             fifo_full,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             we
);

    assign we = valid & ~fifo_full;

    // A load on the drain edge keeps valid high and replaces the data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (we) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/opsum_collector.sv
// Collects e*F psums from the PE array, packs them little-endian into GON FIFO words,
// zero-pads the final partial word and pulses done at the end of the pass.
module opsum_collector
    import noc_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 64,
    parameter int unsigned e_WIDTH   = 8,
    parameter int unsigned F_WIDTH   = 6,
    parameter int unsigned CNT_WIDTH = e_WIDTH + F_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 done,
    input  logic [e_WIDTH-1:0]   e,
    input  logic [F_WIDTH-1:0]   F,
    input  logic                 psum_valid,
    output logic                 psum_ready,
    input  logic [IN_WIDTH-1:0]  psum_in,
    input  logic                 gon_fifo_full,
    output logic                 we_to_gon_fifo,
    output logic [OUT_WIDTH-1:0] dout
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    collector_state_t       state;
    collector_state_t       state_next;
    logic                   done_next;

    logic [CNT_WIDTH-1:0]   total;
    logic [CNT_WIDTH-1:0]   psum_cnt;
    logic [CNT_WIDTH-1:0]   size_product;
    logic [LANE_W-1:0]      lane_cnt;
    logic [OUT_WIDTH-1:0]   asm_word;
    logic [OUT_WIDTH-1:0]   merged_word;

    logic                   out_valid;
    logic                   start_pass;
    logic                   lane_last;
    logic                   last_slot;
    logic                   completing_slot;
    logic                   accept;
    logic                   load_word;

    assign size_product    = CNT_WIDTH'(e) * CNT_WIDTH'(F);
    assign start_pass      = (state == ST_IDLE) & start;
    assign lane_last       = (lane_cnt == LANE_W'(LANES - 1));
    assign last_slot       = ((psum_cnt + CNT_WIDTH'(1)) == total);
    assign completing_slot = lane_last | last_slot;

    // Stall only the slot that would need to load an output register that cannot drain
    assign psum_ready = (state == ST_COLLECT) & ~(completing_slot & out_valid & gon_fifo_full);
    assign accept     = psum_valid & psum_ready;
    assign load_word  = accept & completing_slot;

    // Current assembly word with the incoming psum dropped into its lane
    always_comb begin
        merged_word = asm_word;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (lane_cnt == LANE_W'(i)) begin
                merged_word[i*IN_WIDTH +: IN_WIDTH] = psum_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (size_product == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept & last_slot) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!out_valid) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        done_next = (state_next == ST_DONE);
    end

    // Pass bookkeeping and word assembly; the assembly register empties whenever a word moves out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            total    <= '0;
            psum_cnt <= '0;
            lane_cnt <= '0;
            asm_word <= '0;
        end else begin
            done <= done_next;
            if (start_pass) begin
                total    <= size_product;
                psum_cnt <= '0;
                lane_cnt <= '0;
                asm_word <= '0;
            end else if (accept) begin
                psum_cnt <= psum_cnt + CNT_WIDTH'(1);
                lane_cnt <= lane_last ? '0 : lane_cnt + LANE_W'(1);
                asm_word <= load_word ? '0 : merged_word;
            end
        end
    end

    gon_word_buffer #(
        .WIDTH (OUT_WIDTH)
    ) u_gon_word_buffer (
        .clk       (clk),
        .reset     (reset),
        .load      (load_word),
        .din       (merged_word),
        .fifo_full (gon_fifo_full),
        .dout      (dout),
        .valid     (out_valid),
        .we        (we_to_gon_fifo)
    );

endmodule

// File: tb/tb_opsum_collector.sv
// Self-checking bench for opsum_collector: directed vector table, reset/busy corner cases
// and randomized passes scored against a packing model.
module tb_opsum_collector;

    logic        clk;
    logic        reset;
    logic        start;
    logic        done;
    logic [7:0]  e;
    logic [5:0]  F;
    logic        psum_valid;
    logic        psum_ready;
    logic [15:0] psum_in;
    logic        gon_fifo_full;
    logic        we_to_gon_fifo;
    logic [63:0] dout;

    opsum_collector dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .done           (done),
        .e              (e),
        .F              (F),
        .psum_valid     (psum_valid),
        .psum_ready     (psum_ready),
        .psum_in        (psum_in),
        .gon_fifo_full  (gon_fifo_full),
        .we_to_gon_fifo (we_to_gon_fifo),
        .dout           (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  e;
        logic [5:0]  f;
        logic [15:0] base;
        int          full_cycles;
        int          busy_k;
        int          exp_words;
        logic [63:0] exp_first;
        logic [63:0] exp_last;
        int          exp_stall;
        int          exp_lat;
    } vec_t;

    int          n_pass   = 0;
    int          n_checks = 0;
    int          done_cnt = 0;
    int          we_full_cnt = 0;
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    logic [15:0] data_q[$];

    // Observe FIFO writes and done pulses away from the active edge
    always @(negedge clk) begin
        if (we_to_gon_fifo) begin
            wr_q.push_back(dout);
            if (gon_fifo_full) we_full_cnt++;
        end
        if (done) done_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference packing: four psums per word, first psum in the low bits, last word zero-padded
    task automatic build_expected();
        logic [63:0] w;
        exp_q.delete();
        w = '0;
        for (int i = 0; i < data_q.size(); i++) begin
            w[(i % 4) * 16 +: 16] = data_q[i];
            if ((i % 4) == 3 || i == data_q.size() - 1) begin
                exp_q.push_back(w);
                w = '0;
            end
        end
    endtask

    task automatic do_pass(input string tag, input vec_t v, input int valid_pct,
                           input int full_pct, input bit rnd);
        int n, idx, k, lat, first_stall, base_done, base_wr, base_wf;
        bit seen, acc;
        logic [63:0] got;
        n = int'(v.e) * int'(v.f);
        data_q.delete();
        for (int i = 0; i < n; i++) begin
            if (rnd) data_q.push_back(16'($urandom));
            else     data_q.push_back(v.base + 16'(i));
        end
        build_expected();

        @(posedge clk); #1;
        base_done = done_cnt;
        base_wr   = wr_q.size();
        base_wf   = we_full_cnt;
        e = v.e; F = v.f; start = 1'b1; psum_valid = 1'b0; gon_fifo_full = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        idx = 0; k = 0; lat = -1; first_stall = -1; seen = 1'b0;
        while (!seen && k < 2000) begin
            start = (k == v.busy_k);
            if (k == v.busy_k) begin
                e = 8'd7;
                F = 6'd7;
            end
            psum_valid = (idx < n) && ($urandom_range(99) < valid_pct);
            if (psum_valid) psum_in = data_q[idx];
            else            psum_in = 16'hDEAD;
            gon_fifo_full = (k < v.full_cycles) || ($urandom_range(99) < full_pct);
            @(negedge clk);
            acc = psum_valid && psum_ready;
            if (psum_valid && !psum_ready && first_stall < 0) first_stall = idx;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            k++;
        end
        psum_valid = 1'b0; gon_fifo_full = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check({tag, ".done_seen"}, 64'(seen), 64'd1);
        if (!seen) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
        check({tag, ".accepts"}, 64'(idx), 64'(n));
        check({tag, ".n_words"}, 64'(wr_q.size() - base_wr), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base_wr + i < wr_q.size()) ? wr_q[base_wr + i] : 64'bx;
            check($sformatf("%s.word%0d", tag, i), got, exp_q[i]);
        end
        check({tag, ".done_pulses"}, 64'(done_cnt - base_done), 64'd1);
        check({tag, ".we_while_full"}, 64'(we_full_cnt - base_wf), 64'd0);
        if (v.exp_words >= 0) begin
            check({tag, ".tbl_words"}, 64'(wr_q.size() - base_wr), 64'(v.exp_words));
            if (v.exp_words > 0 && wr_q.size() > base_wr) begin
                check({tag, ".tbl_first"}, wr_q[base_wr], v.exp_first);
                check({tag, ".tbl_last"}, wr_q[wr_q.size() - 1], v.exp_last);
            end
        end
        if (v.exp_stall != -2) check({tag, ".stall_slot"}, 64'(first_stall), 64'(v.exp_stall));
        if (v.exp_lat >= 0)    check({tag, ".done_latency"}, 64'(lat), 64'(v.exp_lat));
    endtask

    vec_t tbl[7];
    vec_t rv;
    int   idx_r, k_r, base_wr_r;

    initial begin
        tbl[0] = '{8'd2, 6'd4, 16'd1,  0, -1, 2, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, -1, 10};
        tbl[1] = '{8'd1, 6'd3, 16'hA,  0, -1, 1, 64'h0000_000C_000B_000A, 64'h0000_000C_000B_000A, -1,  5};
        tbl[2] = '{8'd2, 6'd4, 16'd1, 10, -1, 2, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005,  7, 13};
        tbl[3] = '{8'd0, 6'd5, 16'd0,  0, -1, 0, 64'h0, 64'h0, -1, 0};
        tbl[4] = '{8'd1, 6'd5, 16'd1,  0, -1, 2, 64'h0004_0003_0002_0001, 64'h0000_0000_0000_0005, -1,  7};
        tbl[5] = '{8'd2, 6'd4, 16'd1,  0,  2, 2, 64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005, -1, 10};
        tbl[6] = '{8'd3, 6'd0, 16'd0,  0, -1, 0, 64'h0, 64'h0, -1, 0};

        reset = 1'b1; start = 1'b0; e = '0; F = '0;
        psum_valid = 1'b0; psum_in = '0; gon_fifo_full = 1'b0;
        @(negedge clk);
        check("rst.psum_ready", 64'(psum_ready), 64'd0);
        check("rst.we", 64'(we_to_gon_fifo), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.dout", dout, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_pass($sformatf("vec%0d", i), tbl[i], 100, 0, 1'b0);
        end

        // Reset mid-pass with a completed word still held back by a full FIFO
        @(posedge clk); #1;
        base_wr_r = wr_q.size();
        e = 8'd2; F = 6'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; gon_fifo_full = 1'b1;
        idx_r = 0; k_r = 0;
        while (idx_r < 5 && k_r < 50) begin
            psum_valid = 1'b1;
            psum_in    = 16'(idx_r + 1);
            @(negedge clk);
            if (psum_ready) idx_r++;
            @(posedge clk); #1;
            k_r++;
        end
        check("midrst.accepts", 64'(idx_r), 64'd5);
        check("midrst.pending_dout", dout, 64'h0004_0003_0002_0001);
        reset = 1'b1;
        #1;
        check("midrst.psum_ready", 64'(psum_ready), 64'd0);
        check("midrst.we", 64'(we_to_gon_fifo), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        check("midrst.dout", dout, 64'd0);
        gon_fifo_full = 1'b0;
        @(negedge clk);
        check("midrst.we_released", 64'(we_to_gon_fifo), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; psum_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst.no_writes", 64'(wr_q.size() - base_wr_r), 64'd0);
        rv = '{8'd1, 6'd4, 16'h11, 0, -1, 1, 64'h0014_0013_0012_0011, 64'h0014_0013_0012_0011, -1, 6};
        do_pass("after_rst", rv, 100, 0, 1'b0);

        // Randomized passes with random valid gaps and FIFO backpressure
        for (int i = 0; i < 10; i++) begin
            rv = '{8'($urandom_range(3)), 6'($urandom_range(7)), 16'd0, 0, -1, -1,
                   64'h0, 64'h0, -2, -1};
            do_pass($sformatf("rnd%0d", i), rv, 70, 40, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
